pipelined_divider_u8: RTL and testbench

- Fully pipelined unsigned restoring integer divider: one quotient bit resolved per stage, so a new operation is accepted every clock cycle.
- Sits in the arithmetic datapath as a throughput-oriented replacement for the iterative (non-pipelined) divider.
- Computes quotient and remainder of dividend / divisor with fixed latency.
- Signals each result with a valid pulse and reports pipeline-empty status.

---
 rtl/pipelined_divider_pkg.sv | 28 ++
 rtl/div_restore_stage.sv | 40 ++++
 rtl/pipelined_divider_u8.sv | 131 +++++++++++++
 tb/tb_pipelined_divider_u8.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_divider_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_divider_pkg
// Shared definitions for the pipelined unsigned restoring divider:
//   - DIV_DATA_W   : default operand/result width (also the pipeline depth)
//   - DIV_ALL_ONES : all-ones word, the quotient produced for a zero divisor
//   - div_stage_t  : record carried between pipeline stages
// Optional macro: DIV_BY_ZERO_FLAG_EN adds a zero-divisor flag to the record.
// -----------------------------------------------------------------------------
package pipelined_divider_pkg;

    localparam int DIV_DATA_W = 8;

    localparam logic [DIV_DATA_W-1:0] DIV_ALL_ONES = '1;

    // One in-flight operation. dvd is shifted left one place per stage so its
    // MSB is always the next dividend bit to bring down into the remainder.
    typedef struct packed {
        logic                  valid;
        logic [DIV_DATA_W-1:0] dvd;
        logic [DIV_DATA_W-1:0] dvs;
        logic [DIV_DATA_W-1:0] rem;
        logic [DIV_DATA_W-1:0] quo;
`ifdef DIV_BY_ZERO_FLAG_EN
        logic                  dbz;
`endif
    } div_stage_t;

endpackage

// File: rtl/div_restore_stage.sv
// -----------------------------------------------------------------------------
// div_restore_stage
// One combinational restoring-division step: brings down one dividend bit,
// trial-subtracts the divisor and either keeps the difference or restores.
// Ports:
//   i_rem     [DATA_W] partial remainder entering this step
//   i_dvd_msb [1]      next dividend bit to bring down
//   i_dvs     [DATA_W] divisor
//   o_rem     [DATA_W] partial remainder leaving this step
//   o_qbit    [1]      quotient bit resolved by this step
// -----------------------------------------------------------------------------
module div_restore_stage
    import pipelined_divider_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_dvd_msb,
    input  logic [DATA_W-1:0] i_dvs,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_qbit
);

    logic        [DATA_W:0] w_shift;
    logic signed [DATA_W:0] w_diff;
    logic                   w_borrow;

    assign w_shift = {i_rem, i_dvd_msb};

    // The remainder entering a step is always below the divisor (or the
    // divisor is zero and the shifted value still fits in DATA_W bits), so
    // the DATA_W+1-bit difference never overflows and its sign bit is the
    // borrow of the trial subtraction.
    assign w_diff   = signed'(w_shift - {1'b0, i_dvs});
    assign w_borrow = w_diff[DATA_W];

    assign o_qbit = ~w_borrow;
    assign o_rem  = w_borrow ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];

endmodule

// File: rtl/pipelined_divider_u8.sv
// -----------------------------------------------------------------------------
// pipelined_divider_u8
// Fully pipelined unsigned restoring divider. One quotient bit is resolved per
// stage; a new operation can be accepted every clock. Results appear DATA_W
// clocks after the operands are sampled, in issue order, with a valid pulse.
// Ports:
//   clk          [1]      rising-edge clock
//   reset        [1]      asynchronous active-low reset, clears the pipeline
//   start        [1]      operation request, operands sampled when high
//   dividend     [DATA_W] unsigned dividend
//   divisor      [DATA_W] unsigned divisor
//   valid        [1]      one-cycle pulse per completed operation
//   quotient     [DATA_W] unsigned quotient (holds while valid=0)
//   remainder    [DATA_W] unsigned remainder (holds while valid=0)
//   div_by_zero  [1]      (only with DIV_BY_ZERO_FLAG_EN) divisor was zero
//   result_ready [1]      nothing in flight and valid=0
// Optional macro: DIV_BY_ZERO_FLAG_EN enables the div_by_zero output.
// A zero divisor needs no special handling: the restoring algorithm yields
// quotient = all ones and remainder = dividend on its own.
// -----------------------------------------------------------------------------
module pipelined_divider_u8
    import pipelined_divider_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
`ifdef DIV_BY_ZERO_FLAG_EN
    output logic              div_by_zero,
`endif
    output logic              result_ready
);

    // r_stage[s] holds the operation about to undergo restoring step s.
    div_stage_t        r_stage [DATA_W];
    logic [DATA_W-1:0] w_rem   [DATA_W];
    logic              w_qbit  [DATA_W];

    logic              r_valid;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic              r_dbz;
`endif
    logic              w_busy;

    genvar gs;
    generate
        for (gs = 0; gs < DATA_W; gs++) begin : g_step
            div_restore_stage #(
                .DATA_W (DATA_W)
            ) u_step (
                .i_rem     (r_stage[gs].rem),
                .i_dvd_msb (r_stage[gs].dvd[DATA_W-1]),
                .i_dvs     (r_stage[gs].dvs),
                .o_rem     (w_rem[gs]),
                .o_qbit    (w_qbit[gs])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DATA_W; s++) begin
                r_stage[s] <= '0;
            end
            r_valid <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            // ---- stage 0: operand capture ----
            r_stage[0].valid <= start;
            r_stage[0].dvd   <= dividend;
            r_stage[0].dvs   <= divisor;
            r_stage[0].rem   <= '0;
            r_stage[0].quo   <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
            r_stage[0].dbz   <= (divisor == '0);
`endif

            // ---- stages 1..DATA_W-1: result of step s-1 ----
            for (int s = 0; s < DATA_W - 1; s++) begin
                r_stage[s+1].valid               <= r_stage[s].valid;
                r_stage[s+1].dvd                 <= {r_stage[s].dvd[DATA_W-2:0], 1'b0};
                r_stage[s+1].dvs                 <= r_stage[s].dvs;
                r_stage[s+1].rem                 <= w_rem[s];
                r_stage[s+1].quo                 <= r_stage[s].quo;
                r_stage[s+1].quo[DATA_W-1-s]     <= w_qbit[s];
`ifdef DIV_BY_ZERO_FLAG_EN
                r_stage[s+1].dbz                 <= r_stage[s].dbz;
`endif
            end

            // ---- output register: result of the final step ----
            r_valid <= r_stage[DATA_W-1].valid;
            if (r_stage[DATA_W-1].valid) begin
                r_quo    <= r_stage[DATA_W-1].quo;
                r_quo[0] <= w_qbit[DATA_W-1];
                r_rem    <= w_rem[DATA_W-1];
            end
`ifdef DIV_BY_ZERO_FLAG_EN
            r_dbz <= r_stage[DATA_W-1].valid & r_stage[DATA_W-1].dbz;
`endif
        end
    end

    always_comb begin
        w_busy = r_valid;
        for (int s = 0; s < DATA_W; s++) begin
            w_busy = w_busy | r_stage[s].valid;
        end
    end

    assign valid        = r_valid;
    assign quotient     = r_quo;
    assign remainder    = r_rem;
    assign result_ready = ~w_busy;
`ifdef DIV_BY_ZERO_FLAG_EN
    assign div_by_zero  = r_dbz;
`endif

endmodule

// File: tb/tb_pipelined_divider_u8.sv
`timescale 1ns/1ps
module tb_pipelined_divider_u8;
    import pipelined_divider_pkg::*;

    localparam int LAT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       valid;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       result_ready;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic       div_by_zero;
`endif

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         iss;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic       have_last = 1'b0;
    logic [7:0] last_q;
    logic [7:0] last_r;

    pipelined_divider_u8 #(.DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .valid        (valid),
        .quotient     (quotient),
        .remainder    (remainder),
`ifdef DIV_BY_ZERO_FLAG_EN
        .div_by_zero  (div_by_zero),
`endif
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int iss);
        exp_t e;
        if (b == 8'd0) begin
            e.q = DIV_ALL_ONES;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.iss = iss;
        return e;
    endfunction

    // Output monitor: results are compared in issue order, with latency, and
    // the outputs must hold their last result in cycles without valid.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("quotient", quotient, mon_e.q);
                check_val("remainder", remainder, mon_e.r);
                check_val("latency", cyc - mon_e.iss, LAT);
`ifdef DIV_BY_ZERO_FLAG_EN
                check_val("div_by_zero", div_by_zero, mon_e.z);
`endif
                have_last = 1'b1;
                last_q    = mon_e.q;
                last_r    = mon_e.r;
            end
        end else if (have_last) begin
            check_val("hold_quotient", quotient, last_q);
            check_val("hold_remainder", remainder, last_r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        dividend = 8'($urandom_range(255));
        divisor  = 8'($urandom_range(255));
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b, cyc + 1));
        tick();
        idle_inputs();
    endtask

    task automatic bubble();
        idle_inputs();
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check_val("drain_pending", sb.size(), 0);
        sb.delete();
        tick();
    endtask

    initial begin
        int n;
        int vcount;
        logic [7:0] a;
        logic [7:0] b;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) tick();

        check_val("reset_valid", valid, 0);
        check_val("reset_quotient", quotient, 0);
        check_val("reset_remainder", remainder, 0);
        check_val("reset_ready", result_ready, 1);
`ifdef DIV_BY_ZERO_FLAG_EN
        check_val("reset_dbz", div_by_zero, 0);
`endif

        reset = 1'b1;

        // single operation straight after reset release
        issue(8'd100, 8'd7);
        check_val("busy_after_issue", result_ready, 0);
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_val("single_valid_seen", valid, 1);
        check_val("ready_during_valid", result_ready, 0);
        tick();
        check_val("ready_after_valid", result_ready, 1);
        drain();

        // boundary values and divide by zero
        issue(8'd255, 8'd1);
        issue(8'd5,   8'd10);
        issue(8'd200, 8'd200);
        issue(8'd0,   8'd3);
        issue(8'd37,  8'd0);
        drain();

        // back-to-back stream
        issue(8'd100, 8'd7);
        issue(8'd81,  8'd9);
        issue(8'd250, 8'd3);
        drain();

        // stream with a bubble
        issue(8'd64, 8'd8);
        bubble();
        issue(8'd65, 8'd8);
        drain();

        // reset in the middle of an operation
        issue(8'd99, 8'd4);
        repeat (3) tick();
        reset     = 1'b0;
        have_last = 1'b0;
        #1;
        check_val("midreset_valid", valid, 0);
        check_val("midreset_ready", result_ready, 1);
        sb.delete();
        tick();
        tick();
        reset  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid === 1'b1) vcount++;
        end
        check_val("no_valid_after_reset", vcount, 0);
        issue(8'd99, 8'd4);
        drain();

        // randomized stream with occasional bubbles
        for (int i = 0; i < 100; i++) begin
            a = 8'($urandom_range(255, 1));
            b = 8'($urandom_range(a, 1));
            if ($urandom_range(3) == 0) bubble();
            issue(a, b);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
